// File: rtl/fetch_xlate_icache.sv
// Fetch front end: fully associative ITLB translation followed by a direct-mapped
// instruction-cache lookup, both combinational; table updates land on the clock edge.
module fetch_xlate_icache #(
  parameter int OFFSET         = 12,
  parameter int PHYS_ADDR_SIZE = 20,
  parameter int TLB_ENTRIES    = 4,
  parameter int NUM_LINES      = 4,
  parameter int LINE_WORDS     = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [31:0]                 virtual_address_i,
  input  logic                        privilege_i,
  input  logic [31-OFFSET:0]          w_virtual_page_i,
  input  logic [31-OFFSET:0]          w_phys_page_i,
  input  logic                        write_enable_i,
  input  logic                        fill_valid_i,
  input  logic [PHYS_ADDR_SIZE-1:0]   fill_addr_i,
  input  logic [32*LINE_WORDS-1:0]    fill_data_i,
  output logic [PHYS_ADDR_SIZE-1:0]   phys_address_o,
  output logic                        tlb_ready_o,
  output logic                        tlb_miss_o,
  output logic [31:0]                 inst_o,
  output logic                        cache_miss_o
);

  localparam int VPN_W   = 32 - OFFSET;
  localparam int PPN_W   = PHYS_ADDR_SIZE - OFFSET;
  localparam int TLB_IW  = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;
  localparam int WORD_W  = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int IDX_LSB = 2 + WORD_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = PHYS_ADDR_SIZE - TAG_LSB;

  logic [TLB_ENTRIES-1:0]      tlb_vld;
  logic [VPN_W-1:0]            tlb_vpn [TLB_ENTRIES];
  logic [PPN_W-1:0]            tlb_ppn [TLB_ENTRIES];
  logic [TLB_IW-1:0]           victim;

  logic [NUM_LINES-1:0]        line_vld;
  logic [TAG_W-1:0]            line_tag [NUM_LINES];
  logic [LINE_WORDS-1:0][31:0] line_data [NUM_LINES];

  logic                        lk_hit;
  logic [PPN_W-1:0]            lk_ppn;
  logic                        wr_hit;
  logic [TLB_IW-1:0]           wr_idx;

  logic [WORD_W-1:0]           word_sel;
  logic [IDX_W-1:0]            line_idx;
  logic [TAG_W-1:0]            lookup_tag;
  logic [IDX_W-1:0]            fill_idx;
  logic [TAG_W-1:0]            fill_tag;
  logic                        unused_bits;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit = 1'b0;
    lk_ppn = '0;
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tlb_vld[i] && (tlb_vpn[i] == virtual_address_i[31:OFFSET])) begin
        lk_hit = 1'b1;
        lk_ppn = tlb_ppn[i];
      end
      if (tlb_vld[i] && (tlb_vpn[i] == w_virtual_page_i)) begin
        wr_hit = 1'b1;
        wr_idx = TLB_IW'(i);
      end
    end
  end

  always_comb begin
    tlb_ready_o    = 1'b1;
    tlb_miss_o     = 1'b0;
    phys_address_o = virtual_address_i[PHYS_ADDR_SIZE-1:0];
    if (!privilege_i) begin
      if (lk_hit) begin
        phys_address_o = {lk_ppn, virtual_address_i[OFFSET-1:0]};
      end else begin
        tlb_ready_o    = 1'b0;
        tlb_miss_o     = 1'b1;
        phys_address_o = '0;
      end
    end
  end

  assign word_sel    = phys_address_o[IDX_LSB-1:2];
  assign line_idx    = phys_address_o[TAG_LSB-1:IDX_LSB];
  assign lookup_tag  = phys_address_o[PHYS_ADDR_SIZE-1:TAG_LSB];
  assign fill_idx    = fill_addr_i[TAG_LSB-1:IDX_LSB];
  assign fill_tag    = fill_addr_i[PHYS_ADDR_SIZE-1:TAG_LSB];
  assign unused_bits = ^{fill_addr_i[IDX_LSB-1:0], w_phys_page_i[VPN_W-1:PPN_W]};

  // A translation fault suppresses the cache result so no refill is requested.
  always_comb begin
    cache_miss_o = 1'b0;
    inst_o       = '0;
    if (tlb_ready_o) begin
      if (line_vld[line_idx] && (line_tag[line_idx] == lookup_tag)) begin
        inst_o = line_data[line_idx][word_sel];
      end else begin
        cache_miss_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tlb_vld  <= '0;
      victim   <= '0;
      line_vld <= '0;
    end else begin
      if (write_enable_i && !wr_hit) begin
        tlb_vld[victim] <= 1'b1;
        victim          <= (victim == TLB_IW'(TLB_ENTRIES - 1)) ? '0 : victim + 1'b1;
      end
      if (fill_valid_i) begin
        line_vld[fill_idx] <= 1'b1;
      end
    end
  end

  // Payload arrays carry no reset; their valid bits gate every use.
  always_ff @(posedge clock) begin
    if (write_enable_i) begin
      if (wr_hit) begin
        tlb_ppn[wr_idx] <= w_phys_page_i[PPN_W-1:0];
      end else begin
        tlb_vpn[victim] <= w_virtual_page_i;
        tlb_ppn[victim] <= w_phys_page_i[PPN_W-1:0];
      end
    end
    if (fill_valid_i) begin
      line_tag[fill_idx]  <= fill_tag;
      line_data[fill_idx] <= fill_data_i;
    end
  end

endmodule

// File: tb/tb_fetch_xlate_icache.sv
// Bench for fetch_xlate_icache: directed vectors for the main scenarios, then
// random traffic against a FIFO-map ITLB model and per-index cache model.
module tb_fetch_xlate_icache;

  logic         clock = 1'b0;
  logic         reset;
  logic [31:0]  virtual_address_i;
  logic         privilege_i;
  logic [19:0]  w_virtual_page_i;
  logic [19:0]  w_phys_page_i;
  logic         write_enable_i;
  logic         fill_valid_i;
  logic [19:0]  fill_addr_i;
  logic [127:0] fill_data_i;
  logic [19:0]  phys_address_o;
  logic         tlb_ready_o;
  logic         tlb_miss_o;
  logic [31:0]  inst_o;
  logic         cache_miss_o;

  fetch_xlate_icache #(
    .OFFSET(12), .PHYS_ADDR_SIZE(20), .TLB_ENTRIES(4), .NUM_LINES(4), .LINE_WORDS(4)
  ) dut (
    .clock(clock), .reset(reset),
    .virtual_address_i(virtual_address_i), .privilege_i(privilege_i),
    .w_virtual_page_i(w_virtual_page_i), .w_phys_page_i(w_phys_page_i),
    .write_enable_i(write_enable_i), .fill_valid_i(fill_valid_i),
    .fill_addr_i(fill_addr_i), .fill_data_i(fill_data_i),
    .phys_address_o(phys_address_o), .tlb_ready_o(tlb_ready_o), .tlb_miss_o(tlb_miss_o),
    .inst_o(inst_o), .cache_miss_o(cache_miss_o)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference state: translations as a map plus insertion order; cache per line index.
  logic [7:0]   m_ppn [logic [19:0]];
  logic [19:0]  m_order [$];
  bit           m_lv [int];
  logic [13:0]  m_tag [int];
  logic [127:0] m_data [int];

  typedef struct {
    logic        priv;
    logic [31:0] va;
    logic [19:0] ph;
    logic        rdy;
    logic        tm;
    logic        cm;
    logic [31:0] ins;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [19:0] ph, input logic rdy,
                         input logic tm, input logic cm, input logic [31:0] ins);
    chk({tag, ".phys"},  32'(phys_address_o), 32'(ph));
    chk({tag, ".ready"}, 32'(tlb_ready_o),    32'(rdy));
    chk({tag, ".tmiss"}, 32'(tlb_miss_o),     32'(tm));
    chk({tag, ".cmiss"}, 32'(cache_miss_o),   32'(cm));
    chk({tag, ".inst"},  inst_o,              ins);
  endtask

  task automatic model_eval(input logic priv, input logic [31:0] va,
                            output logic [19:0] ph, output logic rdy, output logic tm,
                            output logic cm, output logic [31:0] ins);
    int k;
    ph = 20'h0; rdy = 1'b0; tm = 1'b0; cm = 1'b0; ins = 32'h0;
    if (priv) begin
      ph = va[19:0];
      rdy = 1'b1;
    end else if (m_ppn.exists(va[31:12])) begin
      ph = {m_ppn[va[31:12]], va[11:0]};
      rdy = 1'b1;
    end else begin
      tm = 1'b1;
    end
    if (rdy) begin
      k = int'(ph[5:4]);
      if (m_lv.exists(k) && m_tag[k] == ph[19:6]) ins = 32'(m_data[k] >> (32 * int'(ph[3:2])));
      else cm = 1'b1;
    end
  endtask

  task automatic model_edge();
    int k;
    if (write_enable_i) begin
      if (m_ppn.exists(w_virtual_page_i)) begin
        m_ppn[w_virtual_page_i] = w_phys_page_i[7:0];
      end else begin
        if (m_order.size() == 4) begin
          m_ppn.delete(m_order[0]);
          void'(m_order.pop_front());
        end
        m_order.push_back(w_virtual_page_i);
        m_ppn[w_virtual_page_i] = w_phys_page_i[7:0];
      end
    end
    if (fill_valid_i) begin
      k = int'(fill_addr_i[5:4]);
      m_lv[k]   = 1'b1;
      m_tag[k]  = fill_addr_i[19:6];
      m_data[k] = fill_data_i;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  initial begin
    logic [19:0] eph;
    logic        erdy, etm, ecm;
    logic [31:0] eins;

    vecs[0] = '{1'b0, 32'h0040_0044, 20'h00000, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 32'h0040_1044, 20'h01044, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 32'h0040_2048, 20'h00048, 1'b1, 1'b0, 1'b0, 32'h3333_3333};
    vecs[3] = '{1'b0, 32'h0040_3ABC, 20'h03ABC, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h0040_4000, 20'h04000, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{1'b1, 32'h0000_0040, 20'h00040, 1'b1, 1'b0, 1'b0, 32'h1111_1111};
    vecs[6] = '{1'b1, 32'hFFF0_004C, 20'h0004C, 1'b1, 1'b0, 1'b0, 32'h4444_4444};
    vecs[7] = '{1'b1, 32'h0000_0140, 20'h00140, 1'b1, 1'b0, 1'b1, 32'h0};
    vecs[8] = '{1'b0, 32'h0040_5000, 20'h00000, 1'b0, 1'b1, 1'b0, 32'h0};

    reset = 1'b1;
    privilege_i = 1'b1; virtual_address_i = 32'h40;
    w_virtual_page_i = '0; w_phys_page_i = '0; write_enable_i = 1'b0;
    fill_valid_i = 1'b0; fill_addr_i = '0; fill_data_i = '0;
    @(negedge clock);
    #1 chk_out("rst", 20'h00040, 1'b1, 1'b0, 1'b1, 32'h0);
    reset = 1'b0;
    step();

    // Fill and lookup of the same line in one cycle, then the hit.
    fill_valid_i = 1'b1; fill_addr_i = 20'h00040;
    fill_data_i = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    virtual_address_i = 32'h48;
    #1 chk_out("fill_same", 20'h00048, 1'b1, 1'b0, 1'b1, 32'h0);
    step();
    fill_valid_i = 1'b0;
    #1 chk_out("fill_next", 20'h00048, 1'b1, 1'b0, 1'b0, 32'h3333_3333);
    virtual_address_i = 32'h140;
    #1 chk_out("conflict", 20'h00140, 1'b1, 1'b0, 1'b1, 32'h0);
    step();

    // ITLB write with a same-cycle user lookup, then the translated hit.
    privilege_i = 1'b0; virtual_address_i = 32'h0040_0044;
    write_enable_i = 1'b1; w_virtual_page_i = 20'h00400; w_phys_page_i = 20'h00000;
    #1 chk_out("tlb_empty", 20'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    write_enable_i = 1'b0;
    #1 chk_out("tlb_new", 20'h00044, 1'b1, 1'b0, 1'b0, 32'h2222_2222);

    for (int i = 1; i <= 4; i++) begin
      write_enable_i = 1'b1;
      w_virtual_page_i = 20'h00400 + 20'(i);
      w_phys_page_i = 20'(i);
      step();
    end
    write_enable_i = 1'b1; w_virtual_page_i = 20'h00402; w_phys_page_i = 20'hABC00;
    step();
    write_enable_i = 1'b0;

    for (int i = 0; i < 9; i++) begin
      privilege_i = vecs[i].priv;
      virtual_address_i = vecs[i].va;
      #1 chk_out($sformatf("vec%0d", i), vecs[i].ph, vecs[i].rdy, vecs[i].tm, vecs[i].cm, vecs[i].ins);
      step();
    end

    // Asynchronous reset between edges.
    privilege_i = 1'b0; virtual_address_i = 32'h0040_2048;
    #2 reset = 1'b1;
    #1 chk_out("arst_user", 20'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    privilege_i = 1'b1; virtual_address_i = 32'h48;
    #1 chk_out("arst_kern", 20'h00048, 1'b1, 1'b0, 1'b1, 32'h0);
    m_ppn.delete(); m_order.delete(); m_lv.delete(); m_tag.delete(); m_data.delete();
    step();
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      privilege_i = ($urandom_range(0, 4) == 0);
      if (privilege_i) virtual_address_i = {12'($urandom), 6'h0, 14'($urandom)};
      else if ($urandom_range(0, 7) == 0) virtual_address_i = $urandom;
      else virtual_address_i = {20'h00400 + 20'($urandom_range(0, 7)), 12'($urandom)};
      write_enable_i = ($urandom_range(0, 3) == 0);
      w_virtual_page_i = 20'h00400 + 20'($urandom_range(0, 7));
      w_phys_page_i = {12'($urandom), 8'($urandom_range(0, 3))};
      fill_valid_i = ($urandom_range(0, 9) < 3);
      fill_addr_i = 20'($urandom_range(0, 16'h3FFF));
      fill_data_i = {$urandom, $urandom, $urandom, $urandom};
      #1;
      model_eval(privilege_i, virtual_address_i, eph, erdy, etm, ecm, eins);
      chk_out($sformatf("rnd%0d", n), eph, erdy, etm, ecm, eins);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
